// File: rtl/less_comparator.sv
// less_comparator: registered unsigned magnitude comparator, out <= (a < b).
// METHOD selects the combinational architecture feeding the result register:
//   0 = behavioural '<', 1 = subtraction borrow-out, 2 = MSB-first ripple,
//   3 = 3-bit chunked compare with priority merge, 4 = (lt, eq) binary tree.
//   Any other value falls back to behavioural. All variants are bit-identical
//   and share the single register stage (latency 1, throughput 1/cycle).
// Optional macro LESS_COMPARATOR_SELFCHECK_EN adds a simulation-only
// cross-check of the selected architecture against behavioural '<'.
`timescale 1ns/1ps

module less_comparator #(
  parameter int WIDTH  = 12,
  parameter int METHOD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out
);

  logic out_d;
  logic out_q;

  generate
    if (METHOD == 1) begin : g_sub
      // Extend both operands by one zero bit; the MSB of the difference is
      // the borrow, which is set exactly when a < b.
      logic [WIDTH:0] diff;
      assign diff  = {1'b0, a} - {1'b0, b};
      // Shifting right by WIDTH leaves only the borrow bit in position 0.
      assign out_d = |(diff >> WIDTH);

    end else if (METHOD == 2) begin : g_ripple
      // Walk from the MSB down; the first differing bit decides the result.
      always_comb begin
        logic lt_r;
        logic gt_r;
        // NOTE: blocking '=' in combinational blocks, every variable gets a
        // default before the loop so no path leaves it unassigned (no latch).
        lt_r = 1'b0;
        gt_r = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
          lt_r = lt_r | (~gt_r & ~a[i] &  b[i]);
          gt_r = gt_r | (~lt_r &  a[i] & ~b[i]);
        end
        out_d = lt_r;
      end

    end else if (METHOD == 3) begin : g_chunk
      localparam int NCH = (WIDTH + 2) / 3;
      localparam int PW  = 3 * NCH;
      // The top chunk is zero-extended when WIDTH is not a multiple of 3.
      logic [PW-1:0] a_pad;
      logic [PW-1:0] b_pad;
      assign a_pad = PW'(a);
      assign b_pad = PW'(b);

      // Compare each 3-bit chunk, then let higher chunks override lower ones.
      always_comb begin
        logic lt_m;
        lt_m = 1'b0;
        for (int k = 0; k < NCH; k++) begin
          if (a_pad[3*k +: 3] < b_pad[3*k +: 3]) begin
            lt_m = 1'b1;
          end else if (a_pad[3*k +: 3] != b_pad[3*k +: 3]) begin
            lt_m = 1'b0;
          end
        end
        out_d = lt_m;
      end

    end else if (METHOD == 4) begin : g_tree
      localparam int LEVELS = $clog2(WIDTH);
      // Reduce (lt, eq) leaf pairs level by level; node j of the next level
      // merges nodes 2j+1 (high) and 2j (low). An unpaired top node passes
      // through. Index WIDTH is a spare slot so every index stays in range.
      always_comb begin
        logic [WIDTH:0] lt_t;
        logic [WIDTH:0] eq_t;
        int             cnt;
        lt_t = {1'b0, ~a & b};
        eq_t = {1'b1, ~(a ^ b)};
        cnt  = WIDTH;
        for (int l = 0; l < LEVELS; l++) begin
          for (int j = 0; j < (WIDTH + 1) / 2; j++) begin
            if (2*j + 1 < cnt) begin
              lt_t[j] = lt_t[2*j+1] | (eq_t[2*j+1] & lt_t[2*j]);
              eq_t[j] = eq_t[2*j+1] & eq_t[2*j];
            end else if (2*j < cnt) begin
              lt_t[j] = lt_t[2*j];
              eq_t[j] = eq_t[2*j];
            end
          end
          cnt = (cnt + 1) / 2;
        end
        out_d = lt_t[0];
      end

    end else begin : g_behav
      assign out_d = (a < b);
    end
  endgenerate

  // Result register: cleared asynchronously, otherwise captures a < b.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking '<=' so all flops update
    // together at the edge regardless of statement order.
    if (!rst_n) begin
      out_q <= 1'b0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

`ifdef LESS_COMPARATOR_SELFCHECK_EN
  // Simulation-only cross-check of the selected architecture against '<'.
  always @(posedge clk) begin
    if (rst_n && (out_d !== (a < b))) begin
      $error("less_comparator METHOD=%0d: a=%h b=%h method_result=%b expected=%b",
             METHOD, a, b, out_d, (a < b));
    end
  end
`endif

endmodule

// File: tb/tb_less_comparator.sv
// Self-checking bench for less_comparator. A default instance (WIDTH=12,
// METHOD=4) is exercised directly; a 4x6 grid of instances covers widths
// {1,7,12,32} against METHOD {0,1,2,3,4,7} on shared stimulus. Expected
// results are queued when operands are driven (falling edge) and popped
// one rising edge later.
`timescale 1ns/1ps

module tb_less_comparator;

  localparam int W  = 12;
  localparam int NW = 4;
  localparam int NM = 6;

  function automatic int width_of(input int wi);
    case (wi)
      0:       return 1;
      1:       return 7;
      2:       return 12;
      default: return 32;
    endcase
  endfunction

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] dut_a;
  logic [W-1:0] dut_b;
  logic         dut_out;
  logic [31:0]  eq_a;
  logic [31:0]  eq_b;
  logic         eq_out [NW][NM];

  int tests_run = 0;
  int fail_cnt  = 0;

  logic          exp_q [$];
  logic [NW-1:0] eqx_q [$];

  always #5 clk = ~clk;

  less_comparator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (dut_a),
    .b     (dut_b),
    .out   (dut_out)
  );

  for (genvar wi = 0; wi < NW; wi++) begin : g_w
    localparam int EW = width_of(wi);
    for (genvar mi = 0; mi < NM; mi++) begin : g_m
      localparam int EM = (mi < 5) ? mi : 7;
      less_comparator #(.WIDTH(EW), .METHOD(EM)) u_cmp (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (eq_a[EW-1:0]),
        .b     (eq_b[EW-1:0]),
        .out   (eq_out[wi][mi])
      );
    end
  end

  // Expected a < b for every grid width, operands truncated to that width.
  function automatic logic [NW-1:0] eq_model(input logic [31:0] x, input logic [31:0] y);
    logic [NW-1:0] r;
    logic [31:0]   m;
    r = '0;
    for (int wi = 0; wi < NW; wi++) begin
      m = (width_of(wi) == 32) ? 32'hFFFF_FFFF : ((32'd1 << width_of(wi)) - 32'd1);
      r[wi] = ((x & m) < (y & m));
    end
    return r;
  endfunction

  // Apply an operand pair on the falling edge and queue its expected result.
  task automatic drive_main(input logic [W-1:0] x, input logic [W-1:0] y, input logic exp_val);
    @(negedge clk);
    dut_a = x;
    dut_b = y;
    exp_q.push_back(exp_val);
  endtask

  task automatic test_reset();
    logic e;
    rst_n = 1'b0;
    dut_a = '0;
    dut_b = 12'd5;
    eq_a  = '0;
    eq_b  = 32'd5;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (dut_out !== 1'b0) begin
        fail_cnt++;
        $display("FAIL reset_hold[%0d]: out=%b expected=0", i, dut_out);
      end
    end
    for (int wi = 0; wi < NW; wi++) begin
      for (int mi = 0; mi < NM; mi++) begin
        tests_run++;
        if (eq_out[wi][mi] !== 1'b0) begin
          fail_cnt++;
          $display("FAIL reset_hold_grid w=%0d m=%0d: out=%b expected=0", width_of(wi), mi, eq_out[wi][mi]);
        end
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(1'b1);
    @(posedge clk); #1;
    tests_run++;
    e = exp_q.pop_front();
    if (dut_out !== e) begin
      fail_cnt++;
      $display("FAIL reset_first_capture: out=%b expected=%b", dut_out, e);
    end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] ta [5] = '{12'h000, 12'h000, 12'hFFF, 12'h7FF, 12'h800};
    logic [W-1:0] tb [5] = '{12'h000, 12'hFFF, 12'h000, 12'h800, 12'h7FF};
    logic         te [5] = '{1'b0,    1'b1,    1'b0,    1'b1,    1'b0};
    logic e;
    for (int i = 0; i < 5; i++) begin
      drive_main(ta[i], tb[i], te[i]);
      @(posedge clk); #1;
      tests_run++;
      e = exp_q.pop_front();
      if (dut_out !== e) begin
        fail_cnt++;
        $display("FAIL boundary[%0d] a=%h b=%h: out=%b expected=%b", i, ta[i], tb[i], dut_out, e);
      end
    end
  endtask

  task automatic test_near_equal();
    logic [W-1:0] base;
    logic [W-1:0] other;
    logic         e;
    base = 12'hA5C;
    for (int i = 0; i < W; i++) begin
      other = base ^ (W'(1) << i);
      for (int s = 0; s < 2; s++) begin
        // Flipping a 0 bit up makes 'other' larger; flipping a 1 makes it smaller.
        if (s == 0) drive_main(base, other, ~base[i]);
        else        drive_main(other, base, base[i]);
        @(posedge clk); #1;
        tests_run++;
        e = exp_q.pop_front();
        if (dut_out !== e) begin
          fail_cnt++;
          $display("FAIL near_equal bit=%0d swap=%0d a=%h b=%h: out=%b expected=%b",
                   i, s, dut_a, dut_b, dut_out, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         e;
    for (int n = 0; n < 3000; n++) begin
      x = W'($urandom);
      y = ($urandom_range(0, 7) == 0) ? x : W'($urandom);
      drive_main(x, y, (x < y));
      @(posedge clk); #1;
      tests_run++;
      e = exp_q.pop_front();
      if (dut_out !== e) begin
        fail_cnt++;
        $display("FAIL back_to_back cycle=%0d a=%h b=%h: out=%b expected=%b", n, x, y, dut_out, e);
      end
    end
  endtask

  task automatic test_method_equiv();
    logic [31:0]   x;
    logic [31:0]   y;
    logic [NW-1:0] ev;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      case ($urandom_range(0, 5))
        0:       begin x = '0;       y = '1;                                  end
        1:       begin x = '1;       y = '0;                                  end
        2:       begin x = $urandom; y = x;                                   end
        3:       begin x = $urandom; y = x ^ (32'd1 << $urandom_range(0, 31)); end
        default: begin x = $urandom; y = $urandom;                            end
      endcase
      eq_a = x;
      eq_b = y;
      eqx_q.push_back(eq_model(x, y));
      @(posedge clk); #1;
      ev = eqx_q.pop_front();
      for (int wi = 0; wi < NW; wi++) begin
        for (int mi = 0; mi < NM; mi++) begin
          tests_run++;
          if (eq_out[wi][mi] !== ev[wi]) begin
            fail_cnt++;
            $display("FAIL method_equiv cycle=%0d w=%0d m=%0d a=%h b=%h: out=%b expected=%b",
                     n, width_of(wi), mi, x, y, eq_out[wi][mi], ev[wi]);
          end
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic e;
    drive_main(12'h010, 12'h020, 1'b1);
    eq_a = '0;
    eq_b = '1;
    @(posedge clk); #1;
    tests_run++;
    e = exp_q.pop_front();
    if (dut_out !== e) begin
      fail_cnt++;
      $display("FAIL mid_reset_before: out=%b expected=%b", dut_out, e);
    end
    // Pulse reset between edges: the output must fall without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (dut_out !== 1'b0) begin
      fail_cnt++;
      $display("FAIL mid_reset_async: out=%b expected=0", dut_out);
    end
    for (int wi = 0; wi < NW; wi++) begin
      for (int mi = 0; mi < NM; mi++) begin
        tests_run++;
        if (eq_out[wi][mi] !== 1'b0) begin
          fail_cnt++;
          $display("FAIL mid_reset_async_grid w=%0d m=%0d: out=%b expected=0", width_of(wi), mi, eq_out[wi][mi]);
        end
      end
    end
    #1 rst_n = 1'b1;
    exp_q.push_back(1'b1);
    @(posedge clk); #1;
    tests_run++;
    e = exp_q.pop_front();
    if (dut_out !== e) begin
      fail_cnt++;
      $display("FAIL mid_reset_recover: out=%b expected=%b", dut_out, e);
    end
    for (int wi = 0; wi < NW; wi++) begin
      for (int mi = 0; mi < NM; mi++) begin
        tests_run++;
        if (eq_out[wi][mi] !== 1'b1) begin
          fail_cnt++;
          $display("FAIL mid_reset_recover_grid w=%0d m=%0d: out=%b expected=1", width_of(wi), mi, eq_out[wi][mi]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    dut_a = '0;
    dut_b = '0;
    eq_a  = '0;
    eq_b  = '0;
    #2;
    test_reset();
    test_boundaries();
    test_near_equal();
    test_back_to_back();
    test_method_equiv();
    test_mid_reset();
    tests_run++;
    if (exp_q.size() != 0 || eqx_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL scoreboard_drain: main=%0d grid=%0d left, expected 0",
               exp_q.size(), eqx_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
